// File: rtl/pu_msp430_clock_switch_ctrl_if.sv
// pu_msp430_clock_switch_ctrl_if: request/status bundle
// between software-side control and the clock switch sequencer.
interface pu_msp430_clock_switch_ctrl_if;
  logic sel_req;
  logic clk1_tog;
  logic fault_clr;
  logic osc1_en;
  logic selection;
  logic sel_status;
  logic busy;
  logic fault;

  modport master (
    output sel_req,
    output clk1_tog,
    output fault_clr,
    input  osc1_en,
    input  selection,
    input  sel_status,
    input  busy,
    input  fault
  );

  modport slave (
    input  sel_req,
    input  clk1_tog,
    input  fault_clr,
    output osc1_en,
    output selection,
    output sel_status,
    output busy,
    output fault
  );
endinterface

// File: rtl/pu_msp430_clock_switch_ctrl.sv
// pu_msp430_clock_switch_ctrl: safe clk_in1 selection sequencer.
// Optional SEL1 watchdog fallback: PU_MSP430_CLKSW_FAILSAFE_EN.
module pu_msp430_clock_switch_ctrl #(
  parameter int SETTLE_CYC   = 64,
  parameter int EDGE_MIN     = 4,
  parameter int WDOG_CYC     = 16,
  parameter int HANDOVER_CYC = 8
) (
  input logic                          clk_in0_inv,
  input logic                          reset,
  pu_msp430_clock_switch_ctrl_if.slave bus
);
  localparam int CM0 =
    (SETTLE_CYC > WDOG_CYC) ? SETTLE_CYC : WDOG_CYC;
  localparam int CMAX =
    (CM0 > HANDOVER_CYC) ? CM0 : HANDOVER_CYC;
  localparam int CW = $clog2(CMAX + 1);
  localparam int EW = $clog2(EDGE_MIN + 1);

  localparam logic [CW-1:0] C_MAX = CW'(CMAX);
  localparam logic [CW-1:0] C_SET = CW'(SETTLE_CYC - 1);
  localparam logic [CW-1:0] C_WDG = CW'(WDOG_CYC);
  localparam logic [CW-1:0] C_HND = CW'(HANDOVER_CYC - 1);
  localparam logic [EW-1:0] E_MAX = EW'(EDGE_MIN);
  localparam logic [EW-1:0] E_LST = EW'(EDGE_MIN - 1);

  typedef enum logic [2:0] {
    S_IDLE0,
    S_WAKE,
    S_CHECK,
    S_SEL1,
    S_DRAIN
  } state_t;

  state_t        r_state;
  state_t        w_state_nx;
  logic [CW-1:0] r_cnt;
  logic [CW-1:0] w_cnt_nx;
  logic [CW-1:0] w_cnt_inc;
  logic [EW-1:0] r_ecnt;
  logic [EW-1:0] w_ecnt_nx;
  logic [EW-1:0] w_ecnt_inc;
  logic          r_s1;
  logic          r_s2;
  logic          r_s3;
  logic          w_edge;
  logic          w_wdog;
  logic          w_fault_set;
  logic          r_fault;
  logic          r_osc;
  logic          r_sel;
  logic          r_stat;
  logic          r_busy;

  assign w_edge = r_s2 ^ r_s3;
  assign w_wdog = ~w_edge & (r_cnt == C_WDG);

  assign w_cnt_inc =
    (r_cnt == C_MAX) ? r_cnt : r_cnt + 1'b1;
  assign w_ecnt_inc =
    (r_ecnt == E_MAX) ? r_ecnt : r_ecnt + 1'b1;

  always_comb begin
    w_state_nx  = r_state;
    w_cnt_nx    = r_cnt;
    w_ecnt_nx   = r_ecnt;
    w_fault_set = 1'b0;
    unique case (r_state)
      S_IDLE0: begin
        if (bus.sel_req & ~r_fault) begin
          w_state_nx = S_WAKE;
          w_cnt_nx   = '0;
        end
      end
      S_WAKE: begin
        w_cnt_nx = w_cnt_inc;
        if (!bus.sel_req) begin
          w_state_nx = S_DRAIN;
          w_cnt_nx   = '0;
        end else if (r_cnt == C_SET) begin
          w_state_nx = S_CHECK;
          w_cnt_nx   = '0;
          w_ecnt_nx  = '0;
        end
      end
      S_CHECK: begin
        if (w_edge) begin
          w_cnt_nx  = '0;
          w_ecnt_nx = w_ecnt_inc;
        end else begin
          w_cnt_nx = w_cnt_inc;
        end
        if (w_wdog) begin
          w_fault_set = 1'b1;
          w_state_nx  = S_DRAIN;
          w_cnt_nx    = '0;
        end else if (!bus.sel_req) begin
          w_state_nx = S_DRAIN;
          w_cnt_nx   = '0;
        end else if (w_edge && r_ecnt == E_LST) begin
          w_state_nx = S_SEL1;
          w_cnt_nx   = '0;
        end
      end
      S_SEL1: begin
`ifdef PU_MSP430_CLKSW_FAILSAFE_EN
        w_cnt_nx = w_edge ? '0 : w_cnt_inc;
        if (w_wdog) begin
          w_fault_set = 1'b1;
          w_state_nx  = S_DRAIN;
          w_cnt_nx    = '0;
        end else if (!bus.sel_req) begin
          w_state_nx = S_DRAIN;
          w_cnt_nx   = '0;
        end
`else
        if (!bus.sel_req) begin
          w_state_nx = S_DRAIN;
          w_cnt_nx   = '0;
        end
`endif
      end
      S_DRAIN: begin
        w_cnt_nx = w_cnt_inc;
        if (r_cnt == C_HND) begin
          w_state_nx = S_IDLE0;
          w_cnt_nx   = '0;
        end
      end
      default: begin
        w_state_nx = S_IDLE0;
        w_cnt_nx   = '0;
      end
    endcase
  end

  // Outputs decode the next state so they are flops, not gates.
  always_ff @(posedge clk_in0_inv or posedge reset) begin
    if (reset) begin
      r_s1    <= 1'b0;
      r_s2    <= 1'b0;
      r_s3    <= 1'b0;
      r_state <= S_IDLE0;
      r_cnt   <= '0;
      r_ecnt  <= '0;
      r_fault <= 1'b0;
      r_osc   <= 1'b0;
      r_sel   <= 1'b0;
      r_stat  <= 1'b0;
      r_busy  <= 1'b0;
    end else begin
      r_s1    <= bus.clk1_tog;
      r_s2    <= r_s1;
      r_s3    <= r_s2;
      r_state <= w_state_nx;
      r_cnt   <= w_cnt_nx;
      r_ecnt  <= w_ecnt_nx;
      r_fault <= w_fault_set |
                 (r_fault & ~bus.fault_clr);
      r_osc   <= (w_state_nx != S_IDLE0);
      r_sel   <= (w_state_nx == S_SEL1);
      r_stat  <= (w_state_nx == S_SEL1);
      r_busy  <= (w_state_nx == S_WAKE) ||
                 (w_state_nx == S_CHECK) ||
                 (w_state_nx == S_DRAIN);
    end
  end

  assign bus.osc1_en    = r_osc;
  assign bus.selection  = r_sel;
  assign bus.sel_status = r_stat;
  assign bus.busy       = r_busy;
  assign bus.fault      = r_fault;
endmodule

// File: tb/tb_pu_msp430_clock_switch_ctrl.sv
// tb_pu_msp430_clock_switch_ctrl: vectors, corner sequences
// and a randomized run against a timestamp-based reference.
module tb_pu_msp430_clock_switch_ctrl;
  localparam int TS = 4;
  localparam int TE = 2;
  localparam int TW = 6;
  localparam int TH = 3;

  localparam int P_IDLE = 0;
  localparam int P_WAKE = 1;
  localparam int P_CHK  = 2;
  localparam int P_SEL  = 3;
  localparam int P_DRN  = 4;

  logic clk;
  logic rst;
  int   n_chk;
  int   n_fail;

  pu_msp430_clock_switch_ctrl_if bus();

  pu_msp430_clock_switch_ctrl #(
    .SETTLE_CYC  (TS),
    .EDGE_MIN    (TE),
    .WDOG_CYC    (TW),
    .HANDOVER_CYC(TH)
  ) dut (
    .clk_in0_inv(clk),
    .reset      (rst),
    .bus        (bus)
  );

  initial begin
    clk = 1'b0;
    forever #5 clk = ~clk;
  end

  // Reference: phase plus timestamps of entry / last edge.
  int       m_ph;
  int       m_k;
  int       m_t0;
  int       m_last;
  int       m_edges;
  bit       m_fault;
  bit [2:0] m_h;

  task automatic m_reset();
    m_ph = P_IDLE; m_k = 0; m_t0 = 0; m_last = 0;
    m_edges = 0; m_fault = 1'b0; m_h = 3'b000;
  endtask

  task automatic m_drain(input bit flt, inout bit set);
    m_ph = P_DRN;
    m_t0 = m_k;
    if (flt) set = 1'b1;
  endtask

  task automatic m_step(input bit req, input bit tg,
                        input bit clr);
    bit e;
    bit set;
    int gap;
    e   = m_h[1] ^ m_h[2];
    set = 1'b0;
    gap = m_k - m_last;
    case (m_ph)
      P_IDLE:
        if (req && !m_fault) begin
          m_ph = P_WAKE; m_t0 = m_k;
        end
      P_WAKE:
        if (!req) m_drain(1'b0, set);
        else if (m_k - m_t0 == TS) begin
          m_ph = P_CHK; m_last = m_k; m_edges = 0;
        end
      P_CHK:
        if (!e && gap == TW + 1) m_drain(1'b1, set);
        else if (!req) m_drain(1'b0, set);
        else if (e) begin
          m_edges++;
          m_last = m_k;
          if (m_edges == TE) m_ph = P_SEL;
        end
      P_SEL: begin
`ifdef PU_MSP430_CLKSW_FAILSAFE_EN
        if (!e && gap == TW + 1) m_drain(1'b1, set);
        else if (!req) m_drain(1'b0, set);
        else if (e) m_last = m_k;
`else
        if (!req) m_drain(1'b0, set);
`endif
      end
      P_DRN:
        if (m_k - m_t0 == TH) m_ph = P_IDLE;
      default: m_ph = P_IDLE;
    endcase
    m_fault = set | (m_fault & !clr);
    m_h = {m_h[1:0], tg};
    m_k++;
  endtask

  function automatic logic [4:0] m_outs();
    logic sl;
    sl = (m_ph == P_SEL);
    return {m_ph != P_IDLE, sl, sl,
            m_ph == P_WAKE || m_ph == P_CHK ||
            m_ph == P_DRN, m_fault};
  endfunction

  function automatic logic [4:0] outs();
    return {bus.osc1_en, bus.selection, bus.sel_status,
            bus.busy, bus.fault};
  endfunction

  function automatic logic [4:0] ex(input bit o, input bit s,
                                    input bit b, input bit f);
    return {o, s, s, b, f};
  endfunction

  task automatic chk(input string nm, input logic [4:0] act,
                     input logic [4:0] exp);
    n_chk++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s t=%0t got=%b want=%b %s", nm, $time,
               act, exp, "(osc,sel,stat,busy,fault)");
    end
  endtask

  task automatic cyc(input bit req, input bit tg,
                     input bit clr);
    bus.sel_req   = req;
    bus.clk1_tog  = tg;
    bus.fault_clr = clr;
    @(posedge clk);
    #1;
    m_step(req, tg, clr);
    chk("model", outs(), m_outs());
  endtask

  typedef struct packed {
    bit         req;
    bit         tog;
    bit         clr;
    logic [4:0] exp;
  } vec_t;

  vec_t tbl[14];

  bit rq;
  bit tg;
  bit cl;
  int seg;
  int mode;
  int per;
  int ph;

  initial begin
    n_chk = 0;
    n_fail = 0;
    rst = 1'b1;
    bus.sel_req = 1'b0;
    bus.clk1_tog = 1'b0;
    bus.fault_clr = 1'b0;
    m_reset();

    tbl[0]  = '{1'b1, 1'b1, 1'b0, 5'b10010};
    tbl[1]  = '{1'b1, 1'b0, 1'b0, 5'b10010};
    tbl[2]  = '{1'b1, 1'b1, 1'b0, 5'b10010};
    tbl[3]  = '{1'b1, 1'b0, 1'b0, 5'b10010};
    tbl[4]  = '{1'b1, 1'b1, 1'b0, 5'b10010};
    tbl[5]  = '{1'b1, 1'b0, 1'b0, 5'b10010};
    tbl[6]  = '{1'b1, 1'b1, 1'b0, 5'b11100};
    tbl[7]  = '{1'b1, 1'b0, 1'b0, 5'b11100};
    tbl[8]  = '{1'b1, 1'b1, 1'b0, 5'b11100};
    tbl[9]  = '{1'b0, 1'b0, 1'b0, 5'b10010};
    tbl[10] = '{1'b1, 1'b1, 1'b0, 5'b10010};
    tbl[11] = '{1'b0, 1'b0, 1'b0, 5'b10010};
    tbl[12] = '{1'b0, 1'b1, 1'b0, 5'b00000};
    tbl[13] = '{1'b0, 1'b0, 1'b0, 5'b00000};

    for (int i = 0; i < 4; i++) begin
      @(posedge clk);
      #1;
      bus.clk1_tog = ~bus.clk1_tog;
      bus.sel_req  = 1'b1;
      chk("reset_hold", outs(), 5'b00000);
    end
    bus.sel_req  = 1'b0;
    bus.clk1_tog = 1'b0;
    rst = 1'b0;
    m_reset();
    for (int i = 0; i < 4; i++) begin
      cyc(1'b0, 1'b0, 1'b0);
      chk("idle_after_reset", outs(), 5'b00000);
    end

    for (int i = 0; i < 14; i++) begin
      cyc(tbl[i].req, tbl[i].tog, tbl[i].clr);
      chk($sformatf("vec%0d", i), outs(), tbl[i].exp);
    end

    repeat (3) cyc(1'b0, 1'b0, 1'b0);
    for (int i = 0; i < 15; i++) begin
      cyc(1'b1, 1'b0, 1'b0);
      chk($sformatf("dead%0d", i), outs(),
          ex(i < 14, 1'b0, i < 14, i >= 11));
    end
    for (int i = 0; i < 4; i++) begin
      cyc(1'b1, 1'b0, 1'b0);
      chk("fault_blocks", outs(), ex(0, 0, 0, 1));
    end
    cyc(1'b1, 1'b0, 1'b1);
    chk("fault_clr", outs(), ex(0, 0, 0, 0));
    cyc(1'b1, 1'b0, 1'b0);
    chk("restart_wake", outs(), ex(1, 0, 1, 0));

    cyc(1'b1, 1'b0, 1'b0);
    chk("wake1", outs(), ex(1, 0, 1, 0));
    cyc(1'b0, 1'b0, 1'b0);
    chk("abort_drain", outs(), ex(1, 0, 1, 0));
    for (int i = 0; i < 3; i++) begin
      cyc(1'b0, 1'b0, 1'b0);
      chk($sformatf("abort%0d", i), outs(),
          ex(i < 2, 1'b0, i < 2, 1'b0));
    end

    for (int i = 0; i < 10; i++) begin
      tg = ~i[0];
      cyc(1'b1, tg, 1'b0);
    end
    chk("fs_in_sel1", outs(), ex(1, 1, 0, 0));
    for (int i = 0; i < 10; i++) cyc(1'b1, 1'b0, 1'b0);
`ifdef PU_MSP430_CLKSW_FAILSAFE_EN
    chk("failsafe", outs(), ex(1, 0, 1, 1));
`else
    chk("no_failsafe", outs(), ex(1, 1, 0, 0));
`endif

    rst = 1'b1;
    #1;
    chk("async_reset", outs(), 5'b00000);
    bus.sel_req = 1'b0;
    bus.clk1_tog = 1'b0;
    @(posedge clk);
    #1;
    rst = 1'b0;
    m_reset();

    rq = 1'b0; tg = 1'b0; seg = 0; mode = 0;
    per = 1; ph = 0;
    for (int n = 0; n < 4000; n++) begin
      if (seg == 0) begin
        mode = $urandom_range(0, 3);
        per  = $urandom_range(1, 9);
        seg  = $urandom_range(20, 80);
      end
      seg--;
      case (mode)
        0: tg = ~tg;
        1: tg = 1'($urandom_range(0, 1));
        3: begin
          ph++;
          if (ph >= per) begin
            ph = 0;
            tg = ~tg;
          end
        end
        default: ;
      endcase
      if ($urandom_range(0, 39) == 0) rq = ~rq;
      cl = ($urandom_range(0, 24) == 0);
      cyc(rq, tg, cl);
      if ($urandom_range(0, 499) == 0) begin
        rst = 1'b1;
        #1;
        chk("rand_reset", outs(), 5'b00000);
        rst = 1'b0;
        m_reset();
      end
    end

    $display("TB_RESULT checks=%0d failures=%0d",
             n_chk, n_fail);
    $finish;
  end
endmodule
